// File: rtl/cpu_fpu_pkg.sv
// Shared FPU definitions: divider FSM states, IEEE-754 single constants, flag bit positions.
package cpu_fpu_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SPECIAL,
    S_NORM_A,
    S_NORM_B,
    S_SETUP,
    S_DIVIDE,
    S_POST,
    S_DENORM,
    S_ROUND,
    S_PACK,
    S_DONE
  } fsm_state_t;

  localparam logic [31:0]        FP_QNAN     = 32'hFFC0_0000;
  localparam logic signed [9:0]  FP_EXP_BIAS = 10'sd127;
  localparam logic signed [9:0]  FP_EMIN     = -10'sd126;
  localparam logic signed [9:0]  FP_EMAX     = 10'sd127;
  // Unbiased values of the all-ones and all-zeros exponent fields
  localparam logic signed [9:0]  FP_EXP_MAXF = 10'sd128;
  localparam logic signed [9:0]  FP_EXP_ZERO = -10'sd127;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  function automatic logic signed [9:0] fp_unbias(input logic [7:0] field);
    return $signed({2'b00, field}) - FP_EXP_BIAS;
  endfunction

endpackage

// File: rtl/cpu_fpu_div_core.sv
// Restoring mantissa divider: one quotient bit per cycle, MSB first, QBITS cycles after start.
module cpu_fpu_div_core #(
  parameter int QBITS = 27
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [23:0]      dividend,
  input  logic [23:0]      divisor,
  output logic             done,
  output logic [QBITS-1:0] quot,
  output logic             rem_nz
);

  localparam logic [4:0] CNT_INIT = 5'(QBITS - 1);

  logic [24:0] rem;
  logic [24:0] rem_sub;
  logic [24:0] rem_next;
  logic        take;
  logic [4:0]  cnt;
  logic        busy;

  always_comb begin
    rem_sub  = rem - {1'b0, divisor};
    take     = rem >= {1'b0, divisor};
    rem_next = take ? rem_sub : rem;
    rem_nz   = rem != '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem  <= {1'b0, dividend};
        quot <= '0;
        cnt  <= CNT_INIT;
        busy <= 1'b1;
      end else if (busy) begin
        quot <= {quot[QBITS-2:0], take};
        // Remainder stays below 2*divisor, so the shifted value fits 25 bits
        rem  <= rem_next << 1;
        if (cnt == '0) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          cnt <= cnt - 5'd1;
        end
      end
    end
  end

endmodule

// File: rtl/cpu_fpu_div.sv
// IEEE-754 single divider (op1/op2), multi-cycle with RNE rounding and subnormal support.
// Optional IEEE exception flags output o_flags enabled by `define CPU_FPU_DIV_FLAGS_EN.
module cpu_fpu_div
  import cpu_fpu_pkg::*;
#(
  parameter int QBITS = 27
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic [31:0] i_op1,
  input  logic [31:0] i_op2,
  output logic        o_ready,
  output logic [31:0] o_result
`ifdef CPU_FPU_DIV_FLAGS_EN
  ,
  output logic [4:0]  o_flags
`endif
);

  fsm_state_t state;

  logic                a_s, b_s, z_s;
  logic signed [9:0]   a_e, b_e, z_e;
  logic [23:0]         a_m, b_m, z_m;
  logic                guard, rnd, sticky;

  logic                core_start, core_done, rem_nz;
  logic [QBITS-1:0]    q;

  logic                a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic signed [9:0]   post_e;
  logic                rnd_inc;
  logic                inexact;
  logic [7:0]          exp_field;

`ifdef CPU_FPU_DIV_FLAGS_EN
  logic                tiny;
`endif

  always_comb begin
    a_nan      = (a_e == FP_EXP_MAXF) && (a_m[22:0] != '0);
    b_nan      = (b_e == FP_EXP_MAXF) && (b_m[22:0] != '0);
    a_inf      = (a_e == FP_EXP_MAXF) && (a_m[22:0] == '0);
    b_inf      = (b_e == FP_EXP_MAXF) && (b_m[22:0] == '0);
    a_zero     = (a_e == FP_EXP_ZERO) && (a_m[22:0] == '0);
    b_zero     = (b_e == FP_EXP_ZERO) && (b_m[22:0] == '0);
    core_start = (state == S_SETUP);
    post_e     = q[QBITS-1] ? z_e : z_e - 10'sd1;
    rnd_inc    = guard & (rnd | sticky | z_m[0]);
    inexact    = guard | rnd | sticky;
    // A subnormal that did not round up into the normal range packs with a zero field
    exp_field  = (z_e == FP_EMIN && !z_m[23]) ? 8'h00 : 8'(z_e + FP_EXP_BIAS);
  end

  cpu_fpu_div_core #(.QBITS(QBITS)) u_core (
    .clock    (i_clock),
    .reset    (i_reset),
    .start    (core_start),
    .dividend (a_m),
    .divisor  (b_m),
    .done     (core_done),
    .quot     (q),
    .rem_nz   (rem_nz)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state   <= S_IDLE;
      o_ready <= 1'b0;
`ifdef CPU_FPU_DIV_FLAGS_EN
      o_flags <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          o_ready <= 1'b0;
`ifdef CPU_FPU_DIV_FLAGS_EN
          o_flags <= '0;
`endif
          if (i_request) begin
            a_s   <= i_op1[31];
            b_s   <= i_op2[31];
            a_e   <= fp_unbias(i_op1[30:23]);
            b_e   <= fp_unbias(i_op2[30:23]);
            a_m   <= {1'b0, i_op1[22:0]};
            b_m   <= {1'b0, i_op2[22:0]};
            state <= S_SPECIAL;
          end
        end

        S_SPECIAL: begin
          if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
            o_result <= FP_QNAN;
`ifdef CPU_FPU_DIV_FLAGS_EN
            o_flags[FLAG_NV] <= 1'b1;
`endif
            o_ready  <= 1'b1;
            state    <= S_DONE;
          end else if (a_inf) begin
            o_result <= {a_s ^ b_s, 8'hFF, 23'h0};
            o_ready  <= 1'b1;
            state    <= S_DONE;
          end else if (b_inf) begin
            o_result <= {a_s ^ b_s, 31'h0};
            o_ready  <= 1'b1;
            state    <= S_DONE;
          end else if (b_zero) begin
            o_result <= {a_s ^ b_s, 8'hFF, 23'h0};
`ifdef CPU_FPU_DIV_FLAGS_EN
            o_flags[FLAG_DZ] <= 1'b1;
`endif
            o_ready  <= 1'b1;
            state    <= S_DONE;
          end else if (a_zero) begin
            o_result <= {a_s ^ b_s, 31'h0};
            o_ready  <= 1'b1;
            state    <= S_DONE;
          end else begin
            if (a_e == FP_EXP_ZERO) a_e <= FP_EMIN;
            else                    a_m[23] <= 1'b1;
            if (b_e == FP_EXP_ZERO) b_e <= FP_EMIN;
            else                    b_m[23] <= 1'b1;
            state <= S_NORM_A;
          end
        end

        S_NORM_A: begin
          if (a_m[23]) begin
            state <= S_NORM_B;
          end else begin
            a_m <= a_m << 1;
            a_e <= a_e - 10'sd1;
          end
        end

        S_NORM_B: begin
          if (b_m[23]) begin
            state <= S_SETUP;
          end else begin
            b_m <= b_m << 1;
            b_e <= b_e - 10'sd1;
          end
        end

        S_SETUP: begin
          z_s   <= a_s ^ b_s;
          z_e   <= a_e - b_e;
          state <= S_DIVIDE;
        end

        S_DIVIDE: begin
          if (core_done) state <= S_POST;
        end

        S_POST: begin
          // Quotient lies in [0.5, 2); the MSB picks which bits form the mantissa
          z_e <= post_e;
          if (q[QBITS-1]) begin
            z_m    <= q[QBITS-1:3];
            guard  <= q[2];
            rnd    <= q[1];
            sticky <= q[0] | rem_nz;
          end else begin
            z_m    <= q[QBITS-2:2];
            guard  <= q[1];
            rnd    <= q[0];
            sticky <= rem_nz;
          end
`ifdef CPU_FPU_DIV_FLAGS_EN
          tiny <= post_e < FP_EMIN;
`endif
          state <= S_DENORM;
        end

        S_DENORM: begin
          if (z_e < FP_EMIN) begin
            z_m    <= z_m >> 1;
            z_e    <= z_e + 10'sd1;
            guard  <= z_m[0];
            rnd    <= guard;
            sticky <= sticky | rnd;
          end else begin
            state <= S_ROUND;
          end
        end

        S_ROUND: begin
          if (rnd_inc) begin
            if (z_m == 24'hFF_FFFF) begin
              z_m <= 24'h80_0000;
              z_e <= z_e + 10'sd1;
            end else begin
              z_m <= z_m + 24'd1;
            end
          end
`ifdef CPU_FPU_DIV_FLAGS_EN
          o_flags[FLAG_NX] <= inexact;
          o_flags[FLAG_UF] <= tiny & inexact;
`endif
          state <= S_PACK;
        end

        S_PACK: begin
          if (z_e > FP_EMAX) begin
            o_result <= {z_s, 8'hFF, 23'h0};
`ifdef CPU_FPU_DIV_FLAGS_EN
            o_flags[FLAG_OF] <= 1'b1;
            o_flags[FLAG_NX] <= 1'b1;
`endif
          end else begin
            o_result <= {z_s, exp_field, z_m[22:0]};
          end
          o_ready <= 1'b1;
          state   <= S_DONE;
        end

        S_DONE: begin
          if (!i_request) begin
            o_ready <= 1'b0;
            state   <= S_IDLE;
          end
        end

        default: begin
          o_ready <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
